// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: turns LW/LBU/SW/SB into a req/gnt/rvalid
// data-memory access and holds the pipeline until the access completes.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] read_data,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    logic                  r_we;
    logic                  r_byte;
    logic [1:0]            r_off;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_be;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [31:0]           r_read_data;
    logic                  r_fault;
    logic [1:0]            r_fault_code;

    logic                  w_memop;
    logic                  w_open;
    logic                  w_accept;
    logic                  w_bad_f3;
    logic                  w_misalign;
    logic                  w_req;
    logic                  w_busy;
    logic                  w_tmo;
    logic [3:0]            w_lane;

    always_comb begin
        w_memop    = (opcode == OP_LOAD) || (opcode == OP_STORE);
        w_open     = (r_state == S_IDLE) || (r_state == S_RESP);
        // rst_n gating keeps stall low while reset is held
        w_accept   = rst_n && start && w_memop && w_open;
        w_bad_f3   = (funct3 != 3'b000) && (funct3 != 3'b010);
        w_misalign = (funct3 == 3'b010) && (addr[1:0] != 2'b00);
        w_lane     = 4'b0001 << addr[1:0];
        w_req      = (r_state == S_REQ);
        w_busy     = w_req || (r_state == S_WAIT);
        w_tmo      = (r_cnt >= CNT_LAST);
    end

    assign stall      = w_busy || w_accept;
    assign done       = (r_state == S_RESP);
    assign read_data  = r_read_data;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;
    assign mem_req    = w_req;
    assign mem_we     = w_req && r_we;
    assign mem_addr   = w_req ? r_addr : 32'd0;
    assign mem_be     = w_req ? r_be : 4'd0;
    assign mem_wdata  = (w_req && r_we) ? r_wdata : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_byte       <= 1'b0;
            r_off        <= 2'b00;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_be         <= 4'd0;
            r_cnt        <= '0;
            r_read_data  <= 32'd0;
            r_fault      <= 1'b0;
            r_fault_code <= 2'b00;
        end else begin
            r_fault      <= 1'b0;
            r_fault_code <= 2'b00;
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_accept) begin
                        r_we    <= (opcode == OP_STORE);
                        r_byte  <= (funct3 == 3'b000);
                        r_off   <= addr[1:0];
                        r_addr  <= {addr[31:2], 2'b00};
                        r_be    <= (funct3 == 3'b010) ? 4'b1111 : w_lane;
                        r_wdata <= (funct3 == 3'b010) ? wdata : {4{wdata[7:0]}};
                        r_cnt   <= '0;
                        if (w_bad_f3) begin
                            r_state      <= S_RESP;
                            r_fault      <= 1'b1;
                            r_fault_code <= 2'b10;
                        end else if (w_misalign) begin
                            r_state      <= S_RESP;
                            r_fault      <= 1'b1;
                            r_fault_code <= 2'b01;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                    // a grant on the last allowed cycle beats the timeout
                    if (mem_gnt) begin
                        r_state <= r_we ? S_RESP : S_WAIT;
                    end else if (w_tmo) begin
                        r_state      <= S_RESP;
                        r_fault      <= 1'b1;
                        r_fault_code <= 2'b11;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                    if (mem_rvalid) begin
                        r_read_data <= r_byte ? (mem_rdata >> {r_off, 3'b000})
                                              : mem_rdata;
                        r_state     <= S_RESP;
                    end else if (w_tmo) begin
                        r_state      <= S_RESP;
                        r_fault      <= 1'b1;
                        r_fault_code <= 2'b11;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver, a memory responder and
// a done-monitor, with expectations from a transaction-level model.
module tb_load_store_unit;
    localparam int TMO = 255;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        stall;
    logic        done;
    logic [31:0] read_data;
    logic        fault;
    logic [1:0]  fault_code;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
        .done(done), .read_data(read_data), .fault(fault),
        .fault_code(fault_code), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fault;
        logic [1:0]  code;
        logic [31:0] rd;
        logic        is_lbu;
        logic        chk_fmt;
        logic [31:0] fmt;
    } sb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gdly;
        int          rdly;
        logic        g_tmo;
        logic        w_tmo;
        int          abort;
    } mx_t;

    sb_t         sb_q[$];
    mx_t         mx_q[$];
    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] ref_rd = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // done monitor
    initial begin : mon
        sb_t s;
        logic [31:0] f;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    s = sb_q.pop_front();
                    chk("fault", fault, s.fault);
                    chk("fault_code", fault_code, s.code);
                    chk("read_data", read_data, s.rd);
                    if (s.chk_fmt) begin
                        f = s.is_lbu ? {24'd0, read_data[7:0]} : read_data;
                        chk("formatter", f, s.fmt);
                    end
                end
            end
        end
    end

    task automatic chk_req(input mx_t m);
        chk("mem_we", mem_we, m.we);
        chk("mem_addr", mem_addr, m.addr);
        chk("mem_be", mem_be, m.be);
        if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
    endtask

    task automatic late_rvalid();
        mem_rvalid = 1'b1;
        mem_rdata = $urandom;
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    task automatic serve(input mx_t m);
        int n;
        if (m.abort == 1) begin
            n = 0;
            while (mem_req === 1'b1 && n < 600) begin
                @(negedge clk);
                n++;
            end
            return;
        end
        if (m.g_tmo) begin
            n = 0;
            while (mem_req === 1'b1 && n < 600) begin
                chk_req(m);
                @(negedge clk);
                n++;
            end
            chk("gnt_timeout_len", n, TMO);
            late_rvalid();
            return;
        end
        for (int k = 0; k < m.gdly; k++) begin
            chk("req_held", mem_req, 1'b1);
            chk_req(m);
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            @(negedge clk);
        end
        chk_req(m);
        mem_rvalid = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("req_drop", mem_req, 1'b0);
        if (m.abort == 2) begin
            n = 0;
            while (rst_n !== 1'b0 && n < 50) begin @(negedge clk); n++; end
            while (rst_n !== 1'b1 && n < 100) begin @(negedge clk); n++; end
            mem_rvalid = 1'b1;
            mem_rdata = 32'h5555AAAA;
            @(negedge clk);
            mem_rvalid = 1'b0;
            return;
        end
        if (m.we) begin
            chk("store_done", done, 1'b1);
            return;
        end
        if (m.w_tmo) begin
            n = 0;
            while (done !== 1'b1 && n < 600) begin @(negedge clk); n++; end
            late_rvalid();
            return;
        end
        repeat (m.rdly) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata = m.rdata;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata = $urandom;
        chk("load_done", done, 1'b1);
    endtask

    // memory responder
    initial begin : rsp
        mx_t m;
        forever begin
            @(negedge clk);
            while (mem_req === 1'b1) begin
                if (mx_q.size() == 0) begin
                    chk("unexpected_req", 32'd1, 32'd0);
                    @(negedge clk);
                end else begin
                    m = mx_q.pop_front();
                    serve(m);
                end
            end
        end
    end

    task automatic issue(input logic ld, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int gdly,
                         input int rdly);
        sb_t s;
        mx_t m;
        int off;
        int cyc;
        int n;
        logic mem;
        off = a % 4;
        s.rd = ref_rd;
        s.chk_fmt = 1'b0;
        s.is_lbu = (f3 == 3'd0);
        s.fmt = 32'd0;
        s.fault = 1'b0;
        s.code = 2'b00;
        mem = 1'b0;
        m = '{default: 0};
        if (f3 != 3'd0 && f3 != 3'd2) begin
            s.fault = 1'b1;
            s.code = 2'b10;
        end else if (f3 == 3'd2 && off != 0) begin
            s.fault = 1'b1;
            s.code = 2'b01;
        end else begin
            mem = 1'b1;
            m.we = !ld;
            m.addr = a - off;
            m.be = 4'd0;
            if (f3 == 3'd2) m.be = 4'hF;
            else m.be[off] = 1'b1;
            m.wdata = (f3 == 3'd2) ? wd : wd[7:0] * 32'h01010101;
            m.rdata = rd;
            m.gdly = gdly;
            m.rdly = rdly;
            cyc = gdly + 1 + (ld ? rdly + 1 : 0);
            m.g_tmo = (gdly + 1 > TMO);
            m.w_tmo = !m.g_tmo && (cyc > TMO);
            if (cyc > TMO) begin
                s.fault = 1'b1;
                s.code = 2'b11;
            end else if (ld) begin
                if (f3 == 3'd2) ref_rd = rd;
                else ref_rd = rd / (32'd1 << (8 * off));
                s.rd = ref_rd;
                s.chk_fmt = 1'b1;
                s.fmt = (f3 == 3'd2) ? rd : {24'd0, rd[8*off +: 8]};
            end
            mx_q.push_back(m);
        end
        sb_q.push_back(s);
        start = 1'b1;
        opcode = ld ? OP_LD : OP_ST;
        funct3 = f3;
        addr = a;
        wdata = wd;
        #1 chk("stall_accept", stall, 1'b1);
        @(negedge clk);
        start = 1'b0;
        opcode = 7'($urandom);
        #1;
        if (mem) begin
            chk("req_after_accept", mem_req, 1'b1);
        end else begin
            chk("noreq_fault", mem_req, 1'b0);
            chk("fault_done", done, 1'b1);
        end
        n = 0;
        while (done !== 1'b1 && n < 700) begin
            chk("stall_busy", stall, 1'b1);
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_seen", done, 1'b1);
        chk("stall_done", stall, 1'b0);
    endtask

    task automatic gap(input int k);
        for (int i = 0; i < k; i++) begin
            start = 1'($urandom_range(0, 1));
            opcode = 7'b0110011;
            funct3 = 3'b010;
            #1 chk("stall_nonmem", stall, 1'b0);
            @(negedge clk);
            #1;
            chk("idle_done", done, 1'b0);
            chk("idle_req", mem_req, 1'b0);
        end
        start = 1'b0;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        mx_t m;
        logic ld;
        logic [2:0] f3;
        logic [31:0] a;
        int r;
        start = 1'b1;
        opcode = OP_LD;
        funct3 = 3'b010;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", stall, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_fault_code", fault_code, 2'b00);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", mem_be, 4'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        issue(1'b1, 3'd2, 32'h100, 32'd0, 32'hDEADBEEF, 0, 1);
        issue(1'b1, 3'd0, 32'h103, 32'd0, 32'hAABBCCDD, 0, 1);
        issue(1'b0, 3'd0, 32'h102, 32'h12345678, 32'd0, 0, 0);
        issue(1'b0, 3'd2, 32'h106, 32'hCAFEF00D, 32'd0, 0, 0);
        issue(1'b1, 3'd1, 32'h100, 32'd0, 32'h0, 0, 0);
        issue(1'b1, 3'd2, 32'h140, 32'd0, 32'h11112222, 255, 0);
        gap(3);
        issue(1'b0, 3'd2, 32'h144, 32'h01020304, 32'd0, 0, 0);
        issue(1'b0, 3'd2, 32'h148, 32'h55667788, 32'd0, 254, 0);
        issue(1'b1, 3'd2, 32'h14C, 32'd0, 32'h0BADF00D, 0, 253);
        issue(1'b1, 3'd0, 32'h14D, 32'd0, 32'h99887766, 0, 254);
        gap(2);
        issue(1'b1, 3'd2, 32'h200, 32'd0, 32'h13579BDF, 0, 0);
        issue(1'b0, 3'd2, 32'h204, 32'h2468ACE0, 32'd0, 0, 0);
        issue(1'b1, 3'd0, 32'h201, 32'd0, 32'hF0E1D2C3, 1, 0);
        gap(2);

        // reset while a request is pending
        m = '{default: 0};
        m.abort = 1;
        mx_q.push_back(m);
        start = 1'b1;
        opcode = OP_LD;
        funct3 = 3'd2;
        addr = 32'h300;
        @(negedge clk);
        start = 1'b0;
        #1 chk("rst_req_up", mem_req, 1'b1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rstreq_mem_req", mem_req, 1'b0);
        chk("rstreq_stall", stall, 1'b0);
        chk("rstreq_done", done, 1'b0);
        chk("rstreq_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        ref_rd = 32'd0;
        @(negedge clk);
        #1;

        // reset while waiting for read data
        m = '{default: 0};
        m.addr = 32'h200;
        m.be = 4'hF;
        m.abort = 2;
        mx_q.push_back(m);
        start = 1'b1;
        opcode = OP_LD;
        funct3 = 3'd2;
        addr = 32'h200;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        chk("wait_stall", stall, 1'b1);
        chk("wait_noreq", mem_req, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rstwait_mem_req", mem_req, 1'b0);
        chk("rstwait_stall", stall, 1'b0);
        chk("rstwait_done", done, 1'b0);
        chk("rstwait_read_data", read_data, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("post_rst_done", done, 1'b0);
            chk("post_rst_read_data", read_data, 32'd0);
        end
        gap(2);

        for (int i = 0; i < 300; i++) begin
            ld = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (r < 4) f3 = 3'd0;
            else if (r < 9) f3 = 3'd2;
            else f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            if (f3 == 3'd2 && $urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            issue(ld, f3, a, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 2));
        end
        gap(5);
        chk("sb_drained", sb_q.size(), 32'd0);
        chk("mx_drained", mx_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage access engine between execute and the data memory port.
- Takes decoded load/store requests (LW, LBU, SW, SB) and drives a req/gnt/rvalid handshake to data memory.
- Stalls the pipeline while an access is outstanding.
- Delivers the returned word, byte-aligned for LBU, on read_data. read_data feeds the downstream load formatter, which zero-extends read_data[7:0] for funct3 000 and passes the word through for 010.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles spent in REQ+WAIT before the access is aborted with a timeout fault.
- CNT_WIDTH, 8: width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pipeline presents an instruction this cycle.
- opcode  in  7  instruction opcode. 0000011 = load, 0100011 = store, anything else = not a memory op.
- funct3  in  3  access size. 000 = byte, 010 = word.
- addr  in  32  effective byte address.
- wdata  in  32  store data (rs2).
- stall  out  1  hold the pipeline.
- done  out  1  one-cycle pulse when an access completes.
- read_data  out  32  load result to the formatter.
- fault  out  1  completed access was aborted.
- fault_code  out  2  01 = misaligned, 10 = unsupported funct3, 11 = timeout.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, {addr[31:2], 2'b00}.
- mem_wdata  out  32  store data lanes.
- mem_be  out  4  byte enables.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  32  load data.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0, including read_data, fault, fault_code, mem_*.
  - Timeout counter clears.
  - mem_req drops immediately, without waiting for a clock edge.
- States: IDLE, REQ, WAIT, RESP.
- Accepting a memory op (IDLE or RESP, start=1, opcode is load or store):
  - Capture opcode, funct3, addr, wdata.
  - stall=1 combinationally in that same cycle.
- Fault checks on accept:
  - funct3 not 000 or 010: go to RESP with fault=1, fault_code=10. No memory access.
  - funct3=010 and addr[1:0]!=00: go to RESP with fault=1, fault_code=01. No memory access.
  - Otherwise: go to REQ and clear the timeout counter.
- Non-memory opcode, or start=0: stay in or return to IDLE. stall=0.
- REQ state:
  - mem_req=1. mem_addr, mem_we, mem_be and mem_wdata come from the captured values and are held stable until mem_gnt.
  - SW: mem_be=1111, mem_wdata=wdata.
  - SB: mem_be=0001<<addr[1:0], mem_wdata={4{wdata[7:0]}}.
  - Loads: mem_be is 1111 for LW and the byte lane for LBU. mem_we=0.
  - On mem_gnt: a store goes to RESP (store complete at grant); a load goes to WAIT.
  - mem_req deasserts the cycle after gnt.
- WAIT state:
  - On mem_rvalid: read_data <= mem_rdata >> (8*addr[1:0]) for LBU, or mem_rdata for LW. Then go to RESP.
  - mem_rvalid is sampled only in WAIT. The earliest legal response is one cycle after gnt. rvalid in any other state is ignored.
- Timeout:
  - The counter increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES, go to RESP with fault=1, fault_code=11. read_data is left unchanged.
  - A gnt or rvalid arriving in the same cycle as the timeout takes priority over the timeout.
- RESP state (exactly one cycle):
  - done=1, stall=0.
  - fault and fault_code are valid for this cycle only; they return to 0 the next cycle unless the new access faults.
  - An accepted start in RESP begins the next access back-to-back.
- read_data holds its value until the next successful load completes. Stores and faults do not alter it.
- stall = (state is REQ or WAIT) OR (accepting a memory op in IDLE/RESP).
- Reset mid-access abandons the transaction. No done is produced.

Test Plan:
- LW, addr=0x100, gnt on the 1st REQ cycle, rvalid 2 cycles later with rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=1111. read_data=0xDEADBEEF and done=1 exactly one cycle after rvalid. stall high from start until the done cycle.
- LBU, addr=0x103, rdata=0xAABBCCDD -> read_data=0x000000AA. Formatter output is 0x000000AA.
- SB, addr=0x102, wdata=0x12345678 -> mem_we=1, mem_be=0100, mem_wdata=0x78787878. done one cycle after gnt. read_data unchanged.
- SW, addr=0x106 -> no mem_req. done with fault_code=01 in the next cycle. LW with funct3=001 -> fault_code=10.
- LW where gnt is held low for 255 cycles (TIMEOUT_CYCLES=255) -> fault_code=11, done pulse. A late rvalid afterwards is ignored and read_data is unchanged.
- Back-to-back LW/SW with start held during RESP -> second mem_req the cycle after done. rst_n pulsed low while in WAIT -> mem_req, stall and done go to 0 immediately, and a following rvalid is ignored.
